// File: rtl/seg7_capture_if.sv
// seg7_capture_if
// Groups the multiplexed 7-segment display bus being observed and the
// readback values reconstructed from it.
//   an      4  anode enables, active-low, an[i]=0 selects digit i
//   seg_in  7  segment lines, active-high, bit6=a ... bit0=g
//   digits 16  captured values, digits[4i+3:4i] is digit i
//   valid   4  digit i captured and refreshed recently
//   err     4  last stable pattern on digit i was not a known code
//   upd     1  one-cycle pulse on every capture
// master: the side driving the display bus and reading results.
// slave : the capture block.
interface seg7_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg_in;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;

  modport master (
    output an,
    output seg_in,
    input  digits,
    input  valid,
    input  err,
    input  upd
  );

  modport slave (
    input  an,
    input  seg_in,
    output digits,
    output valid,
    output err,
    output upd
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture
// Watches a multiplexed 4-digit common-anode display bus and rebuilds the
// hex value shown on each digit position. A digit is captured once the
// synchronized anode/segment pair has been identical for STABLE_CYCLES
// samples; each digit's valid flag expires after TIMEOUT cycles without
// a fresh capture.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    seg7_capture_if.slave (an, seg_in in; digits, valid, err, upd out)
// Parameters:
//   STABLE_CYCLES  identical samples needed before a capture (2..255)
//   TIMEOUT        cycles without refresh before valid clears (fits 21 bits)
module seg7_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 1048576
) (
  input logic           clk,
  input logic           reset,
  seg7_capture_if.slave bus
);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam int          TW        = 21;
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [7:0]  STABLE_V  = 8'(STABLE_CYCLES);

  // Two-flop synchronizers plus one extra stage used for the "same" test.
  logic [3:0] m_an;
  logic [3:0] s_an;
  logic [3:0] p_an;
  logic [6:0] m_seg;
  logic [6:0] s_seg;
  logic [6:0] p_seg;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic [7:0] cnt_inc;
  logic       capture;

  logic       one_hot;
  logic [1:0] cap_idx;
  logic       same;
  logic [3:0] dec_val;
  logic       dec_ill;

  logic [15:0]   digits_r;
  logic [3:0]    valid_r;
  logic [3:0]    err_r;
  logic          upd_r;
  logic [TW-1:0] rcnt [4];

  // Anodes idle high, so the reset value is "no digit selected".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_an  <= 4'b1111;
      s_an  <= 4'b1111;
      p_an  <= 4'b1111;
      m_seg <= 7'd0;
      s_seg <= 7'd0;
      p_seg <= 7'd0;
    end else begin
      m_an  <= bus.an;
      s_an  <= m_an;
      p_an  <= s_an;
      m_seg <= bus.seg_in;
      s_seg <= m_seg;
      p_seg <= s_seg;
    end
  end

  // Exactly one anode low selects a digit; anything else (blanking gaps,
  // ghosting with two anodes low) is ignored.
  always_comb begin
    one_hot = 1'b1;
    cap_idx = 2'd0;
    case (s_an)
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  assign same = (s_an == p_an) && (s_seg == p_seg);

  // Inverse of the team's hex decoder, including its 6/7/9 forms and the
  // all-off pattern used as the blank (F) code.
  always_comb begin
    dec_val = 4'h0;
    dec_ill = 1'b0;
    case (s_seg)
      7'b1111110: dec_val = 4'h0;
      7'b0110000: dec_val = 4'h1;
      7'b1101101: dec_val = 4'h2;
      7'b1111001: dec_val = 4'h3;
      7'b0110011: dec_val = 4'h4;
      7'b1011011: dec_val = 4'h5;
      7'b0011111: dec_val = 4'h6;
      7'b1110000: dec_val = 4'h7;
      7'b1111111: dec_val = 4'h8;
      7'b1110011: dec_val = 4'h9;
      7'b0001101: dec_val = 4'hA;
      7'b0011001: dec_val = 4'hB;
      7'b0100011: dec_val = 4'hC;
      7'b1001011: dec_val = 4'hD;
      7'b0001111: dec_val = 4'hE;
      7'b0000000: dec_val = 4'hF;
      default:    dec_ill = 1'b1;
    endcase
  end

  assign cnt_inc = cnt + 8'd1;

  // HELD exists so a long dwell produces only one capture; the counter is
  // restarted at 1 because the first sample of a new value already counts.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (one_hot) begin
          cnt_nx   = 8'd1;
          state_nx = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!one_hot) begin
          state_nx = ST_WAIT;
        end else if (!same) begin
          cnt_nx = 8'd1;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == STABLE_V) begin
            capture  = 1'b1;
            state_nx = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!one_hot) begin
          state_nx = ST_WAIT;
        end else if (!same) begin
          cnt_nx   = 8'd1;
          state_nx = ST_COUNT;
        end
      end
      default: begin
        state_nx = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Per-digit capture and refresh timeout. Capture takes priority over an
  // expiry landing on the same edge; digits and err survive expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_r <= 16'd0;
      valid_r  <= 4'd0;
      err_r    <= 4'd0;
      upd_r    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      upd_r <= capture;
      for (int i = 0; i < 4; i++) begin
        if (capture && (cap_idx == 2'(i))) begin
          digits_r[4*i +: 4] <= dec_val;
          err_r[i]           <= dec_ill;
          valid_r[i]         <= !dec_ill;
          rcnt[i]            <= '0;
        end else if (rcnt[i] == TIMEOUT_V) begin
          valid_r[i] <= 1'b0;
        end else begin
          rcnt[i] <= rcnt[i] + TW'(1);
          if ((rcnt[i] + TW'(1)) == TIMEOUT_V) begin
            valid_r[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.digits = digits_r;
  assign bus.valid  = valid_r;
  assign bus.err    = err_r;
  assign bus.upd    = upd_r;

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reverse direction of the team's hex-to-7-segment decoder: observes a multiplexed 4-digit common-anode display bus (active-low anodes plus active-high segment lines) and reconstructs the 4-bit digit value shown on each position.
- Used as a loopback checker and readback path on the Spartan-3E PicoBlaze board.
- Captured digits, per-digit valid/error flags and an update strobe are presented to a PicoBlaze input port.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before a capture; legal range 2..255.
- TIMEOUT, 1048576, cycles without a refresh of a digit before its valid flag clears; 21-bit counter per digit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- an  in  4  anode enables, active-low; an[i]=0 selects digit i.
- seg_in  in  7  segment lines, active-high; bit6=a, bit5=b … bit0=g.
- digits  out  16  captured values; digits[4i+3:4i] is digit i.
- valid  out  4  valid[i]=1: digit i captured and refreshed within TIMEOUT.
- err  out  4  err[i]=1: last stable pattern on digit i was not in the code table.
- upd  out  1  one-cycle pulse on every capture.

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0, synchronizer flops are an=4'b1111 and seg=0, counters are 0, and the FSM is in WAIT. A mid-operation reset clears everything immediately, including the valid flags.
- Synchronizer: an and seg_in each pass through 2 flops. Define s_an, s_seg as the second-stage values and p_an, p_seg as those values registered one cycle later.
- Code table (seg -> value):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3
  - 0110011->4, 1011011->5, 0011111->6, 1110000->7
  - 1111111->8, 1110011->9, 0001101->A, 0011001->B
  - 0100011->C, 1001011->D, 0001111->E, 0000000->F
  - Any other pattern is illegal: decoded value 0, illegal=1.
- one_hot: s_an has exactly one 0 bit.
- same: s_an==p_an and s_seg==p_seg.
- FSM states WAIT, COUNT, HELD, with 8-bit stable counter cnt:
  - WAIT: if one_hot, cnt<=1 and go to COUNT; otherwise stay.
  - COUNT: if !one_hot, go to WAIT. Else if !same, cnt<=1 and stay. Else cnt<=cnt+1; when cnt+1==STABLE_CYCLES, capture and go to HELD.
  - HELD: stay while one_hot && same. On a change to another one-hot value, cnt<=1 and go to COUNT. On !one_hot, go to WAIT.
  - Only one capture happens per dwell, however long the dwell lasts.
- Capture of digit i (index of the 0 bit in s_an), registered on the capturing edge:
  - digits[4i+3:4i]<=decoded value (0 if illegal).
  - err[i]<=illegal.
  - valid[i]<=!illegal.
  - upd pulses high for exactly that cycle.
  - Other digit slots are unchanged.
- Latency: an input held stable from cycle t is captured at edge t+2+STABLE_CYCLES (±1 for input phase); outputs change at that edge.
- Timeout: each digit has a refresh counter. It resets to 0 on capture of that digit and otherwise increments, saturating at TIMEOUT. When it reaches TIMEOUT, valid[i]<=0; digits and err are retained.
- Simultaneous timeout and capture on the same digit: capture wins.
- Blank pattern 0000000 decodes to F and is valid, consistent with the decoder's blank code.
- All-anodes-off gaps (an=1111) between digits are normal blanking. They return the FSM to WAIT and never capture.

Test Plan:
1. Reset, then an=1110, seg_in=1111001 held 40 cycles -> single upd pulse about 18 cycles after the input is applied; digits=16'h0003, valid=0001, err=0000.
2. Scan 4 digits with 1110/1101/1011/0111 showing 2,A,D,7, 64-cycle dwell each with 4-cycle 1111 gaps -> digits=16'h7DA2, valid=1111, exactly 4 upd pulses per scan round.
3. Segment glitch: seg_in toggles for 1 cycle every 10 cycles with STABLE_CYCLES=16 -> no upd and digits unchanged; removing the glitches gives a capture.
4. Illegal pattern 1010101 on an=1011 -> err=0100, valid[2]=0, digit 2 field=0, upd pulses; the next legal pattern clears err[2].
5. Two anodes low (an=1100) for 100 cycles -> no capture; TIMEOUT reduced to 64 -> valid drops to 0000 after 64 cycles, digits retained.
6. Assert reset mid-COUNT, 3 cycles before the expected capture -> all outputs 0 immediately, no upd; after release a fresh full STABLE_CYCLES dwell is required.
